// File: rtl/uart_rx.sv
// 8N1 UART receiver with selectable bit rate and a two-flop input synchronizer.
// The divisor is latched at start detect so baud_sel may change freely mid-frame.
module uart_rx #(
  parameter int unsigned DIV_9600  = 5208,
  parameter int unsigned DIV_19200 = 2604,
  parameter int unsigned DIV_38400 = 1302,
  parameter int unsigned DIV_57600 = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] baud_sel,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e      state_q;
  logic        rx_meta_q;
  logic        rx_sync_q;
  logic        rx_prev_q;
  logic [1:0]  baud_q;
  logic [12:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        ferr_q;

  logic [12:0] div;
  logic [12:0] div_m1;
  logic [12:0] half_m1;

  always_comb begin
    div = 13'(DIV_9600);
    unique case (baud_q)
      2'b00: div = 13'(DIV_9600);
      2'b01: div = 13'(DIV_19200);
      2'b10: div = 13'(DIV_38400);
      2'b11: div = 13'(DIV_57600);
    endcase
    div_m1  = div - 13'd1;
    half_m1 = (div >> 1) - 13'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      baud_q    <= 2'b00;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Require a falling edge so a low stop bit is not taken as the next start.
          if (!rx_sync_q && rx_prev_q) begin
            state_q <= StStart;
            cnt_q   <= '0;
            bit_q   <= '0;
            baud_q  <= baud_sel;
          end
        end
        StStart: begin
          if (cnt_q == half_m1) begin
            cnt_q   <= '0;
            state_q <= rx_sync_q ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + 13'd1;
          end
        end
        StData: begin
          if (cnt_q == div_m1) begin
            cnt_q   <= '0;
            shift_q <= {rx_sync_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + 13'd1;
          end
        end
        StStop: begin
          if (cnt_q == div_m1) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            if (rx_sync_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 13'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are queued with their start time and checked against
// the 9.5-bit latency window, pulse kind, received byte and busy behaviour.
module tb_uart_rx;
  // Bit periods are scaled down from the 50 MHz defaults to keep the run short.
  localparam int unsigned D0 = 651;
  localparam int unsigned D1 = 326;
  localparam int unsigned D2 = 163;
  localparam int unsigned D3 = 109;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] baud_sel;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .DIV_9600 (D0),
    .DIV_19200(D1),
    .DIV_38400(D2),
    .DIV_57600(D3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_sel  (baud_sel),
    .rx        (rx),
    .data      (data),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned fall;
    int unsigned div;
    logic [7:0]  b;
    bit          err;
  } exp_t;

  exp_t        expq[$];
  exp_t        cur;
  int unsigned lat;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned n_valid = 0;
  logic [7:0]  model_data = 8'h00;

  function automatic int unsigned div_of(input logic [1:0] s);
    case (s)
      2'b00:   return D0;
      2'b01:   return D1;
      2'b10:   return D2;
      default: return D3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: every queued frame must produce exactly one pulse within 9.5*DIV +-4.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (rst === 1'b0) begin
      check("pulse_exclusive", 32'(data_valid & frame_err), 32'd0);
      if (data_valid || frame_err) begin
        if (expq.size() == 0) begin
          check("unexpected_pulse", {30'd0, data_valid, frame_err}, 32'd0);
        end else begin
          cur = expq.pop_front();
          lat = cyc - cur.fall;
          check("pulse_kind", {30'd0, data_valid, frame_err}, cur.err ? 32'd1 : 32'd2);
          n_checks++;
          if (2 * lat + 8 < 19 * cur.div || 2 * lat > 19 * cur.div + 8) begin
            n_fail++;
            $display("FAIL pulse_latency: got %0d cycles, required %0d.5 +-4", lat,
                     (19 * cur.div) / 2);
          end
          check("busy_at_pulse", 32'(busy), 32'd0);
          if (data_valid) begin
            model_data = cur.b;
            n_valid++;
          end
        end
      end else if (expq.size() != 0) begin
        cur = expq[0];
        lat = cyc - cur.fall;
        if (2 * lat > 19 * cur.div + 8) begin
          n_checks++;
          n_fail++;
          $display("FAIL missing_pulse: none after %0d cycles, required byte %0h err %0d",
                   lat, cur.b, cur.err);
          void'(expq.pop_front());
        end else if (lat >= 4 && 2 * lat + 8 < 19 * cur.div) begin
          check("busy_in_frame", 32'(busy), 32'd1);
        end
      end
      check("data_hold", 32'(data), 32'(model_data));
    end
  end

  task automatic hold(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; abort_bit >= 0 resets the DUT partway through that data bit.
  task automatic send_frame(input logic [1:0] sel, input logic [7:0] b, input bit stop,
                            input bit toggle, input int abort_bit);
    int unsigned d;
    exp_t e;
    d = div_of(sel);
    baud_sel = sel;
    rx = 1'b0;
    if (abort_bit < 0) begin
      e.fall = cyc;
      e.div  = d;
      e.b    = b;
      e.err  = !stop;
      expq.push_back(e);
    end
    hold(d);
    for (int i = 0; i < 8; i++) begin
      if (abort_bit == i) begin
        rst = 1'b1;
        rx = 1'b1;
        model_data = 8'h00;
        hold(2);
        rst = 1'b0;
        hold(d);
        return;
      end
      rx = b[i];
      if (toggle) baud_sel = 2'($urandom);
      hold(d);
    end
    rx = stop;
    hold(d);
    rx = 1'b1;
  endtask

  task automatic glitch(input logic [1:0] sel, input int unsigned len);
    baud_sel = sel;
    rx = 1'b0;
    hold(len);
    rx = 1'b1;
    hold(div_of(sel) / 2 + 8);
    check("glitch_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0]  s;
    bit          st;
    int unsigned gap;
    rst = 1'b1;
    rx = 1'b1;
    baud_sel = 2'b00;
    hold(2);
    rst = 1'b0;
    hold(1);
    check("reset_data", 32'(data), 32'h00);
    check("reset_valid", 32'(data_valid), 32'd0);
    check("reset_ferr", 32'(frame_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    hold(5);

    send_frame(2'b00, 8'hA5, 1'b1, 1'b0, -1);
    hold(20);
    check("a5_data", 32'(data), 32'hA5);
    check("a5_count", n_valid, 32'd1);

    send_frame(2'b11, 8'h00, 1'b1, 1'b0, -1);
    send_frame(2'b11, 8'hFF, 1'b1, 1'b0, -1);
    hold(20);
    check("b2b_data", 32'(data), 32'hFF);
    check("b2b_count", n_valid, 32'd3);

    send_frame(2'b01, 8'h3C, 1'b0, 1'b0, -1);
    hold(20);
    check("ferr_data_kept", 32'(data), 32'hFF);
    check("ferr_count", n_valid, 32'd3);

    glitch(2'b10, 50);

    send_frame(2'b00, 8'h5A, 1'b1, 1'b1, -1);
    hold(20);
    check("toggle_data", 32'(data), 32'h5A);

    send_frame(2'b00, 8'hC3, 1'b1, 1'b0, 4);
    check("abort_data", 32'(data), 32'h00);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_count", n_valid, 32'd4);

    send_frame(2'b00, 8'h81, 1'b1, 1'b0, -1);
    hold(20);
    check("after_abort_data", 32'(data), 32'h81);
    check("after_abort_count", n_valid, 32'd5);

    for (int k = 0; k < 6; k++) begin
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) glitch(s, $urandom_range(1, div_of(s) / 2 - 4));
      st = ($urandom_range(0, 3) != 0);
      send_frame(s, 8'($urandom), st, 1'b0, -1);
      gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 100);
      if (!st && gap < 8) gap = 8;
      hold(gap);
    end

    hold(200);
    check("all_frames_seen", expq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter DIV_9600, default 5208, clk cycles per bit at baud_sel=00 (50 MHz clk).
REQ-002 SHALL provide parameter DIV_19200, default 2604, clk cycles per bit at baud_sel=01.
REQ-003 SHALL provide parameter DIV_38400, default 1302, clk cycles per bit at baud_sel=10.
REQ-004 SHALL provide parameter DIV_57600, default 868, clk cycles per bit at baud_sel=11.
REQ-005 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port baud_sel  input  2  bit-rate select, same encoding as the baud generator (00=9600, 01=19200, 10=38400, 11=57600).
REQ-008 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have port data  output  8  last correctly framed byte received.
REQ-010 SHALL have port data_valid  output  1  one-cycle pulse: new byte present on data.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-013 SHALL receive 8N1 frames: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-014 SHALL pass rx through a two-flop synchronizer, with both flops reset to 1; all FSM decisions SHALL use the synchronized value.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-016 IDLE: when synchronized rx=0, go to START, clear bit counter and cycle counter, and latch baud_sel into an internal register.
REQ-017 SHALL take the divisor DIV from the latched baud_sel only; a baud_sel change mid-frame SHALL have no effect until the next start detect.
REQ-018 START: when cycle counter reaches DIV/2-1, sample rx.
  - rx=1: false start; return to IDLE, with no output pulse.
  - rx=0: go to DATA with cycle counter cleared.
REQ-019 DATA: when cycle counter reaches DIV-1, shift the sampled rx into the MSB of the shift register (shift right) and clear the cycle counter; after the 8th sample, go to STOP.
REQ-020 STOP: when cycle counter reaches DIV-1, sample rx.
  - rx=1: load data from the shift register and pulse data_valid for exactly 1 cycle.
  - rx=0: pulse frame_err for 1 cycle and leave data unchanged.
  - Either case: return to IDLE on the same edge.
REQ-021 SHALL return to IDLE at mid-stop-bit, so a start bit immediately following the stop bit is detected with no lost frame.
REQ-022 SHALL hold data stable between data_valid pulses.
REQ-023 SHALL never assert data_valid and frame_err in the same cycle.
REQ-024 SHALL assert data_valid within 9.5*DIV ±4 clk cycles of the rx falling edge at the pin.
REQ-025 SHALL size the cycle counter at ≥13 bits; the counter SHALL never exceed DIV-1 in any state.

Reset
REQ-026 On rst=1 at a clock edge, the block SHALL apply all of the following, regardless of state:
  - FSM state = IDLE;
  - data = 8'h00, data_valid = 0, frame_err = 0, busy = 0;
  - synchronizer flops = 1;
  - counters cleared, latched baud_sel = 00.
REQ-027 Reset mid-frame SHALL abort the frame without an output pulse; reception SHALL resume at the next falling edge after rst deasserts.

Verification
REQ-028 Reset check: hold rst 2 cycles with rx=1 -> data=00, data_valid=0, frame_err=0, busy=0.
REQ-029 Single byte at 9600: baud_sel=00, send 0xA5 with bit period 5208 clk.
  - data=A5; one data_valid pulse about 49476 clk after the start edge; frame_err stays 0.
REQ-030 Back-to-back bytes at 57600: baud_sel=11, send 0x00 then 0xFF with no idle gap.
  - Two data_valid pulses, data=00 then FF; busy drops between frames.
REQ-031 Framing error: send 0x3C at 19200 with the stop bit driven 0.
  - One frame_err pulse; data_valid stays 0; data retains its prior value.
REQ-032 Glitch rejection: at 38400, pulse rx low for 400 clk (< 651).
  - FSM returns to IDLE; no data_valid or frame_err pulse.
REQ-033 Robustness: toggle baud_sel during a 9600 frame of 0x5A -> data=5A received correctly.
  - Then assert rst mid-frame -> no pulse; a following 0x81 frame is received correctly.
